// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS-subset core with req/valid instruction and data ports.
// Ports: clk, rst (sync, active high); imem_req/addr/rdata/valid fetch port;
// dmem_req/we/addr/wdata/rdata/valid data port; instret retired count;
// halt set in TRAP. Optional macro MIPS_ILLEGAL_TRAP_EN traps on
// unsupported instructions instead of executing them as NOPs.
module multicycle_mips_core #(
  parameter int          DADDR_W  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_valid,
  output logic [31:0]        instret,
  output logic               halt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [31:0] sx;
  logic [4:0]  dst;

  logic is_r;
  logic i_sll, i_srl, i_add, i_sub;
  logic i_and, i_or, i_slt, i_jr;
  logic i_addi, i_lw, i_sw;
  logic i_beq, i_bne, i_j, i_jal;
  logic do_wb, do_mem, taken;

  logic [31:0] alu;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign imem_addr = pc;

  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign sh = ir[10:6];
  assign fn = ir[5:0];
  assign sx = {{16{ir[15]}}, ir[15:0]};

  assign is_r   = (op == 6'h00);
  assign i_sll  = is_r && (fn == 6'h00);
  assign i_srl  = is_r && (fn == 6'h02);
  assign i_jr   = is_r && (fn == 6'h08);
  assign i_add  = is_r && (fn == 6'h20);
  assign i_sub  = is_r && (fn == 6'h22);
  assign i_and  = is_r && (fn == 6'h24);
  assign i_or   = is_r && (fn == 6'h25);
  assign i_slt  = is_r && (fn == 6'h2a);
  assign i_j    = (op == 6'h02);
  assign i_jal  = (op == 6'h03);
  assign i_beq  = (op == 6'h04);
  assign i_bne  = (op == 6'h05);
  assign i_addi = (op == 6'h08);
  assign i_lw   = (op == 6'h23);
  assign i_sw   = (op == 6'h2b);

  assign do_wb = i_sll | i_srl | i_add | i_sub |
                 i_and | i_or | i_slt | i_addi;
  assign do_mem = i_lw | i_sw;
  assign taken = (i_beq && (a == b)) ||
                 (i_bne && (a != b));

  // pc already holds the fetch address + 4 by EXEC
  assign br_tgt = pc + {sx[29:0], 2'b00};
  assign j_tgt  = {pc[31:28], ir[25:0], 2'b00};
  assign dst    = is_r ? rd : rt;

  always_comb begin
    alu = 32'h0;
    unique case (1'b1)
      i_sll: alu = b << sh;
      i_srl: alu = b >> sh;
      i_add: alu = a + b;
      i_sub: alu = a - b;
      i_and: alu = a & b;
      i_or:  alu = a | b;
      i_slt: alu = {31'h0, $signed(a) < $signed(b)};
      i_addi, i_lw, i_sw: alu = a + sx;
      default: alu = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      a          <= 32'h0;
      b          <= 32'h0;
      res        <= 32'h0;
      instret    <= 32'h0;
      halt       <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req && imem_valid) begin
            ir       <= imem_rdata;
            pc       <= pc + 32'd4;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (1'b1)
            do_wb: begin
              res   <= alu;
              state <= S_WB;
            end
            do_mem: begin
              dmem_req   <= 1'b1;
              dmem_we    <= i_sw;
              dmem_addr  <= alu[DADDR_W+1:2];
              dmem_wdata <= b;
              state      <= S_MEM;
            end
            i_beq, i_bne: begin
              if (taken) pc <= br_tgt;
              instret  <= instret + 32'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            i_j, i_jal: begin
              pc <= j_tgt;
              if (i_jal) rf[31] <= pc + 32'd4;
              instret  <= instret + 32'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            i_jr: begin
              pc       <= a;
              instret  <= instret + 32'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            default: begin
`ifdef MIPS_ILLEGAL_TRAP_EN
              halt  <= 1'b1;
              state <= S_TRAP;
`else
              instret  <= instret + 32'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEM: begin
          if (dmem_valid) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (i_sw) begin
              instret  <= instret + 32'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              res   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (dst != 5'd0) rf[dst] <= res;
          instret  <= instret + 32'd1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_mips_core.md
Name: multicycle_mips_core

Overview:
- Multicycle MIPS-subset core; successor to the single-cycle core.
- Replaces fixed single-cycle instruction/data memory timing with variable-latency request/valid handshakes on separate instruction and data ports.
- Parametrised in data-memory address width and reset vector; adds a retired-instruction counter.
- Sits between instruction/data SRAM wrappers and the test harness.

Parameters:
- DADDR_W, 7, data-memory word-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  instruction fetch request; held until imem_valid.
- imem_addr  out  32  byte address of fetch, equals PC.
- imem_rdata  in  32  instruction word; sampled when imem_req and imem_valid.
- imem_valid  in  1  fetch complete this cycle.
- dmem_req  out  1  data access request; held until dmem_valid.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req.
- dmem_addr  out  DADDR_W  word address, ALU result[DADDR_W+1:2].
- dmem_wdata  out  32  store data (rt value).
- dmem_rdata  in  32  load data; sampled when dmem_req and dmem_valid.
- dmem_valid  in  1  data access complete this cycle.
- instret  out  32  retired-instruction count; wraps at 2^32.
- halt  out  1  core stopped in TRAP.

Behaviour:
- Reset, synchronous (rst high at edge):
  - PC = RESET_PC; state = FETCH; all 32 registers = 0.
  - instret = 0; halt = 0; imem_req = 0; dmem_req = 0; dmem_we = 0.
- rst overrides any in-flight access. An outstanding req drops on the next edge. A late valid is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are registered.
- FETCH:
  - imem_req = 1.
  - On imem_valid: IR <= imem_rdata; PC <= PC+4; go to DECODE.
  - imem_req deasserts the following cycle.
  - valid may be asserted in the first req cycle, giving zero wait states.
- DECODE: latch A = reg[rs] and B = reg[rt]; go to EXEC.
- EXEC:
  - R-type (op 0x00), by funct: 0x00 sll, 0x02 srl, 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt. All go to WB.
  - slt is a signed compare.
  - addi (0x08): A + sext(imm); go to WB.
  - lw (0x23) / sw (0x2b): address = A + sext(imm); go to MEM.
  - beq (0x04) / bne (0x05): if taken, PC <= PC + (sext(imm)<<2), where PC is already +4. Go to FETCH.
  - j (0x02): PC <= {PC[31:28], target, 2'b00}; go to FETCH.
  - jal (0x03): as j, plus reg[31] <= PC+4 (i.e. original PC+8).
  - jr (op 0, funct 0x08): PC <= A.
  - Every instruction that leaves EXEC for FETCH retires there.
- MEM:
  - dmem_req = 1; dmem_we = (op == sw).
  - On dmem_valid: sw retires and goes to FETCH; lw latches dmem_rdata and goes to WB.
- WB:
  - Destination is rd for R-type, rt for addi/lw.
  - Writes to reg 0 are discarded; reg 0 always reads 0. Retire; go to FETCH.
- Arithmetic wraps modulo 2^32; no overflow exceptions. Shift amount is shamt[4:0].
- Retire: instret <= instret+1 on the retire edge.
- CPI with zero-wait memory:
  - R/addi: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne/j/jal/jr: 3.
  - Each memory wait cycle adds 1.
- Unsupported op/funct: see Optional Feature.
- TRAP: terminal state; only rst leaves it. No requests are issued in TRAP.

Optional Feature:
- Macro MIPS_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode/funct in EXEC goes to TRAP. halt <= 1 on that edge. PC holds the address of the faulting instruction + 4. instret is not incremented.
- Undefined: an unsupported instruction executes as a NOP. It retires in EXEC, instret increments, and the core goes to FETCH. halt stays 0.

Test Plan:
- Reset with RESET_PC=0x40: hold rst for 2 cycles → first imem_req with imem_addr=0x40; instret=0, halt=0.
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,4(r0) with zero-wait memory → dmem_req with we=1, addr=1, wdata=12; instret=4 after 4+4+4+4=16 cycles.
- lw r4,4(r0) with dmem_valid delayed 3 cycles, memory returns 0xDEADBEEF → dmem_req held exactly 4 cycles; r4=0xDEADBEEF; instruction takes 8 cycles.
- beq r1,r1,-1 at PC 0x10 → next fetch address 0x10; bne r1,r1,-1 → next fetch 0x14; jal 0x100 at PC 0x20 → fetch 0x400, r31=0x28.
- addi r0,r0,9 then add r5,r0,r0 → r5=0. slt with r1=0xFFFFFFFF, r2=1 → 1. instret wraps from 0xFFFFFFFF to 0.
- Opcode 0x3F at PC 0x8: with MIPS_ILLEGAL_TRAP_EN, halt=1, no further imem_req, instret unchanged. Without the macro, next fetch is at 0xC and instret increments. Assert rst mid-MEM with the request pending → dmem_req drops the next cycle, and fetch restarts at RESET_PC.
